// File: rtl/counter_update_gen.sv
// Meters bursty add/sub events onto the counter's 2-bit incr/decr ports and sequences reinit behind them.
// Optional COUNTER_UPDATE_GEN_NET_CANCEL_EN nets pending totals so only one direction issues per cycle.
module counter_update_gen #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2,
    parameter int AMT_W  = 3,
    parameter int PEND_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_valid,
    input  logic [AMT_W-1:0]  add_amt,
    output logic              add_ready,
    input  logic              sub_valid,
    input  logic [AMT_W-1:0]  sub_amt,
    output logic              sub_ready,
    input  logic              reinit_req_valid,
    input  logic [WIDTH-1:0]  reinit_req_value,
    output logic              reinit_req_ready,
    output logic              reinit,
    output logic [WIDTH-1:0]  initial_value,
    output logic              incr_valid,
    output logic [STEP_W-1:0] incr,
    output logic              decr_valid,
    output logic [STEP_W-1:0] decr,
    output logic              idle
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REINIT = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] MAX_STEP  = PEND_W'((2 ** STEP_W) - 1);
    // Highest pending value that can still absorb a full-size event without wrapping.
    localparam logic [PEND_W-1:0] ACC_LIMIT = PEND_W'((2 ** PEND_W) - (2 ** AMT_W));

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_inc_q, pend_inc_d;
    logic [PEND_W-1:0] pend_dec_q, pend_dec_d;
    logic [WIDTH-1:0]  stored_q, stored_d;
    logic [WIDTH-1:0]  init_val_q, init_val_d;
    logic              reinit_q, reinit_d;
    logic              incr_vld_q, incr_vld_d;
    logic              decr_vld_q, decr_vld_d;
    logic [STEP_W-1:0] incr_q, incr_d;
    logic [STEP_W-1:0] decr_q, decr_d;

    logic              add_acc, sub_acc, reinit_acc;
    logic [PEND_W-1:0] add_ext, sub_ext;
    logic [STEP_W-1:0] issue_i, issue_d;
    logic [PEND_W-1:0] drain_inc, drain_dec;

    function automatic logic [STEP_W-1:0] sat_step(input logic [PEND_W-1:0] v);
        if (v > MAX_STEP) begin
            sat_step = MAX_STEP[STEP_W-1:0];
        end else begin
            sat_step = v[STEP_W-1:0];
        end
    endfunction

    assign add_ready        = (state_q == ST_RUN) && (pend_inc_q <= ACC_LIMIT);
    assign sub_ready        = (state_q == ST_RUN) && (pend_dec_q <= ACC_LIMIT);
    assign reinit_req_ready = (state_q == ST_RUN);

    assign add_acc    = add_valid && add_ready;
    assign sub_acc    = sub_valid && sub_ready;
    assign reinit_acc = reinit_req_valid && reinit_req_ready;
    assign add_ext    = add_acc ? PEND_W'(add_amt) : '0;
    assign sub_ext    = sub_acc ? PEND_W'(sub_amt) : '0;

`ifdef COUNTER_UPDATE_GEN_NET_CANCEL_EN
    logic [PEND_W-1:0] net_amt;

    // The smaller total cancels against the larger; only the surplus is issued.
    always_comb begin
        net_amt   = '0;
        issue_i   = '0;
        issue_d   = '0;
        drain_inc = '0;
        drain_dec = '0;
        if (pend_inc_q >= pend_dec_q) begin
            net_amt   = pend_inc_q - pend_dec_q;
            issue_i   = sat_step(net_amt);
            drain_inc = net_amt - PEND_W'(issue_i);
        end else begin
            net_amt   = pend_dec_q - pend_inc_q;
            issue_d   = sat_step(net_amt);
            drain_dec = net_amt - PEND_W'(issue_d);
        end
    end
`else
    always_comb begin
        issue_i   = sat_step(pend_inc_q);
        issue_d   = sat_step(pend_dec_q);
        drain_inc = pend_inc_q - PEND_W'(issue_i);
        drain_dec = pend_dec_q - PEND_W'(issue_d);
    end
`endif

    always_comb begin
        state_d    = state_q;
        pend_inc_d = pend_inc_q;
        pend_dec_d = pend_dec_q;
        stored_d   = stored_q;
        init_val_d = init_val_q;
        reinit_d   = 1'b0;
        incr_vld_d = 1'b0;
        incr_d     = '0;
        decr_vld_d = 1'b0;
        decr_d     = '0;
        case (state_q)
            ST_RUN, ST_FLUSH: begin
                incr_vld_d = (issue_i != '0);
                incr_d     = issue_i;
                decr_vld_d = (issue_d != '0);
                decr_d     = issue_d;
                pend_inc_d = drain_inc + add_ext;
                pend_dec_d = drain_dec + sub_ext;
                if ((state_q == ST_RUN) && reinit_acc) begin
                    state_d  = ST_FLUSH;
                    stored_d = reinit_req_value;
                end else if ((state_q == ST_FLUSH) && (pend_inc_q == '0) && (pend_dec_q == '0)) begin
                    state_d = ST_REINIT;
                end
            end
            ST_REINIT: begin
                reinit_d   = 1'b1;
                init_val_d = stored_q;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pend_inc_q <= '0;
            pend_dec_q <= '0;
            stored_q   <= '0;
            init_val_q <= '0;
            reinit_q   <= 1'b0;
            incr_vld_q <= 1'b0;
            incr_q     <= '0;
            decr_vld_q <= 1'b0;
            decr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            stored_q   <= stored_d;
            init_val_q <= init_val_d;
            reinit_q   <= reinit_d;
            incr_vld_q <= incr_vld_d;
            incr_q     <= incr_d;
            decr_vld_q <= decr_vld_d;
            decr_q     <= decr_d;
        end
    end

    assign reinit        = reinit_q;
    assign initial_value = init_val_q;
    assign incr_valid    = incr_vld_q;
    assign incr          = incr_q;
    assign decr_valid    = decr_vld_q;
    assign decr          = decr_q;
    assign idle          = (state_q == ST_RUN) && (pend_inc_q == '0) && (pend_dec_q == '0)
                           && !incr_vld_q && !decr_vld_q;

endmodule

// File: tb/tb_counter_update_gen.sv
// Bench for counter_update_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_counter_update_gen;

    localparam int LIMIT = 64 - 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add_valid = 1'b0;
    logic [2:0] add_amt = '0;
    logic       add_ready;
    logic       sub_valid = 1'b0;
    logic [2:0] sub_amt = '0;
    logic       sub_ready;
    logic       reinit_req_valid = 1'b0;
    logic [3:0] reinit_req_value = '0;
    logic       reinit_req_ready;
    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic       decr_valid;
    logic [1:0] decr;
    logic       idle;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending totals, a flushing flag, and a pulse owed on the next edge.
    int m_pinc = 0, m_pdec = 0, m_stored = 0;
    bit m_flushing = 0, m_pulse_next = 0;
    int e_incr = 0, e_decr = 0, e_init = 0;
    bit e_reinit = 0;

    logic [14:0] act_vec;

    counter_update_gen dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_amt(add_amt), .add_ready(add_ready),
        .sub_valid(sub_valid), .sub_amt(sub_amt), .sub_ready(sub_ready),
        .reinit_req_valid(reinit_req_valid), .reinit_req_value(reinit_req_value),
        .reinit_req_ready(reinit_req_ready),
        .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr),
        .decr_valid(decr_valid), .decr(decr), .idle(idle)
    );

    always #5 clk = ~clk;

    assign act_vec = {reinit, initial_value, incr_valid, incr, decr_valid, decr, idle,
                      add_ready, sub_ready, reinit_req_ready};

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic bit m_run();
        return !m_flushing && !m_pulse_next;
    endfunction

    function automatic bit m_idle();
        return m_run() && m_pinc == 0 && m_pdec == 0 && e_incr == 0 && e_decr == 0;
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [14:0] v;
        v = {e_reinit, 4'(e_init), (e_incr != 0), 2'(e_incr), (e_decr != 0), 2'(e_decr),
             m_idle(), m_run() && m_pinc <= LIMIT, m_run() && m_pdec <= LIMIT, m_run()};
        return v;
    endfunction

    task automatic model_edge();
        int aa, sa, ii, di, npi, npd, net;
        if (rst) begin
            m_pinc = 0; m_pdec = 0; m_stored = 0; m_flushing = 0; m_pulse_next = 0;
            e_incr = 0; e_decr = 0; e_init = 0; e_reinit = 0;
            return;
        end
        if (m_pulse_next) begin
            e_reinit = 1; e_init = m_stored; e_incr = 0; e_decr = 0; m_pulse_next = 0;
            return;
        end
        aa = (add_valid && m_run() && m_pinc <= LIMIT) ? int'(add_amt) : 0;
        sa = (sub_valid && m_run() && m_pdec <= LIMIT) ? int'(sub_amt) : 0;
        e_reinit = 0;
`ifdef COUNTER_UPDATE_GEN_NET_CANCEL_EN
        if (m_pinc >= m_pdec) begin
            net = m_pinc - m_pdec; ii = min3(net); di = 0; npi = net - ii + aa; npd = sa;
        end else begin
            net = m_pdec - m_pinc; di = min3(net); ii = 0; npd = net - di + sa; npi = aa;
        end
`else
        net = 0;
        ii = min3(m_pinc); di = min3(m_pdec);
        npi = m_pinc - ii + aa; npd = m_pdec - di + sa;
`endif
        if (m_flushing && m_pinc == 0 && m_pdec == 0) begin
            m_flushing = 0; m_pulse_next = 1;
        end else if (m_run() && reinit_req_valid) begin
            m_flushing = 1; m_stored = int'(reinit_req_value);
        end
        m_pinc = npi; m_pdec = npd; e_incr = ii; e_decr = di;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiesce();
        add_valid = 0; sub_valid = 0; reinit_req_valid = 0; rst = 0;
        for (int i = 0; i < 40 && !(m_idle() && !e_reinit); i++) tick();
    endtask

    task automatic test_reset();
        rst = 1; add_valid = 1; add_amt = 3'd7;
        tick();
        checks++;
        if ({reinit, initial_value, incr_valid, incr, decr_valid, decr} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {reinit, initial_value, incr_valid, incr, decr_valid, decr});
        end
        rst = 0; add_valid = 0;
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b want=1", idle); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (incr_valid !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_accept cyc=%0d incr_valid=%b idle=%b want 0/1", c, incr_valid, idle);
            end
        end
    endtask

    task automatic test_burst();
        logic [2:0] want_incr [0:3];
        logic       want_vld  [0:3];
        quiesce();
        want_vld[0] = 0; want_vld[1] = 1; want_vld[2] = 1; want_vld[3] = 0;
        want_incr[0] = 0; want_incr[1] = 3; want_incr[2] = 2; want_incr[3] = 0;
        add_valid = 1; add_amt = 3'd5;
        tick();
        add_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (incr_valid !== want_vld[c-1] || incr !== want_incr[c-1][1:0]) begin
                errors++;
                $display("FAIL burst cyc=%0d incr_valid=%b incr=%0d want %b/%0d", c, incr_valid, incr,
                         want_vld[c-1], want_incr[c-1]);
            end
            tick();
        end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL burst_idle got=%b want=1", idle); end
    endtask

    task automatic test_simultaneous();
        quiesce();
        add_valid = 1; add_amt = 3'd2; sub_valid = 1; sub_amt = 3'd1;
        tick();
        add_valid = 0; sub_valid = 0;
        tick();
        checks++;
`ifdef COUNTER_UPDATE_GEN_NET_CANCEL_EN
        if (incr_valid !== 1'b1 || incr !== 2'd1 || decr_valid !== 1'b0 || decr !== 2'd0) begin
            errors++;
            $display("FAIL simul_net got iv=%b i=%0d dv=%b d=%0d want 1/1/0/0", incr_valid, incr, decr_valid, decr);
        end
`else
        if (incr_valid !== 1'b1 || incr !== 2'd2 || decr_valid !== 1'b1 || decr !== 2'd1) begin
            errors++;
            $display("FAIL simul got iv=%b i=%0d dv=%b d=%0d want 1/2/1/1", incr_valid, incr, decr_valid, decr);
        end
`endif
        tick();
        checks++;
        if (incr_valid !== 1'b0 || decr_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_after iv=%b dv=%b want 0/0", incr_valid, decr_valid);
        end
    endtask

    task automatic test_backpressure();
        int acc_total, out_total;
        bit saw_drop, saw_return;
        quiesce();
        acc_total = 0; out_total = 0; saw_drop = 0; saw_return = 0;
        add_valid = 1; add_amt = 3'd7;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (add_ready !== (m_pinc <= LIMIT)) begin
                errors++;
                $display("FAIL bp_ready cyc=%0d got=%b want=%b pend=%0d", c, add_ready, m_pinc <= LIMIT, m_pinc);
            end
            if (m_pinc > LIMIT) saw_drop = 1;
            else if (saw_drop) saw_return = 1;
            if (m_pinc <= LIMIT) acc_total += 7;
            if (incr_valid) out_total += int'(incr);
            tick();
        end
        add_valid = 0;
        for (int c = 0; c < 30; c++) begin
            if (incr_valid) out_total += int'(incr);
            tick();
        end
        checks++;
        if (!(saw_drop && saw_return)) begin
            errors++;
            $display("FAIL bp_drop_return drop=%b return=%b want 1/1", saw_drop, saw_return);
        end
        checks++;
        if (out_total != acc_total) begin
            errors++;
            $display("FAIL bp_total got=%0d want=%0d", out_total, acc_total);
        end
    endtask

    task automatic setup_reinit();
        quiesce();
        add_valid = 1; add_amt = 3'd4;
        tick();
        add_valid = 0;
        reinit_req_valid = 1; reinit_req_value = 4'd9;
        checks++;
        if (reinit_req_ready !== 1'b1) begin errors++; $display("FAIL reinit_req_ready got=%b want=1", reinit_req_ready); end
        tick();
        reinit_req_valid = 0;
    endtask

    task automatic test_reinit_mid();
        setup_reinit();
        checks++;
        if (add_ready !== 1'b0 || reinit_req_ready !== 1'b0 || incr_valid !== 1'b1 || incr !== 2'd3) begin
            errors++;
            $display("FAIL reinit_flush1 ar=%b rr=%b iv=%b i=%0d want 0/0/1/3", add_ready, reinit_req_ready, incr_valid, incr);
        end
        tick();
        checks++;
        if (add_ready !== 1'b0 || incr_valid !== 1'b1 || incr !== 2'd1 || reinit !== 1'b0) begin
            errors++;
            $display("FAIL reinit_flush2 ar=%b iv=%b i=%0d rei=%b want 0/1/1/0", add_ready, incr_valid, incr, reinit);
        end
        tick();
        checks++;
        if (incr_valid !== 1'b0 || reinit !== 1'b0 || add_ready !== 1'b0) begin
            errors++;
            $display("FAIL reinit_gap iv=%b rei=%b ar=%b want 0/0/0", incr_valid, reinit, add_ready);
        end
        tick();
        checks++;
        if (reinit !== 1'b1 || initial_value !== 4'd9 || incr_valid !== 1'b0 || add_ready !== 1'b1
            || sub_ready !== 1'b1 || reinit_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reinit_pulse rei=%b iv_val=%0d incr_valid=%b ready=%b%b%b want 1/9/0/111",
                     reinit, initial_value, incr_valid, add_ready, sub_ready, reinit_req_ready);
        end
        tick();
        checks++;
        if (reinit !== 1'b0 || initial_value !== 4'd9) begin
            errors++;
            $display("FAIL reinit_after rei=%b iv_val=%0d want 0/9", reinit, initial_value);
        end
    endtask

    task automatic test_reset_mid_flush();
        bit pulsed;
        setup_reinit();
        rst = 1;
        tick();
        rst = 0;
        pulsed = 0;
        for (int c = 0; c < 6; c++) begin
            if (reinit === 1'b1) pulsed = 1;
            tick();
        end
        checks++;
        if (pulsed || idle !== 1'b1 || add_ready !== 1'b1 || reinit_req_ready !== 1'b1 || incr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flush pulsed=%b idle=%b ar=%b rr=%b iv=%b want 0/1/1/1/0",
                     pulsed, idle, add_ready, reinit_req_ready, incr_valid);
        end
    endtask

    task automatic test_random();
        quiesce();
        for (int c = 0; c < 500; c++) begin
            rst              = ($urandom_range(0, 99) == 0);
            add_valid        = ($urandom_range(0, 1) == 1);
            add_amt          = 3'($urandom_range(0, 7));
            sub_valid        = ($urandom_range(0, 2) == 0);
            sub_amt          = 3'($urandom_range(0, 7));
            reinit_req_valid = ($urandom_range(0, 19) == 0);
            reinit_req_value = 4'($urandom_range(0, 15));
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
            end
            tick();
        end
        rst = 0;
        quiesce();
        checks++;
        if (act_vec !== exp_vec() || idle !== 1'b1) begin
            errors++;
            $display("FAIL random_drain got=%h want=%h idle=%b", act_vec, exp_vec(), idle);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_simultaneous();
        test_backpressure();
        test_reinit_mid();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
